// File: rtl/adder_pkg.sv
// Shared types for the sequential prefix adder library: controller states
// and the generate/propagate pair carried through the prefix levels.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREFIX = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Combining with this operand leaves the high-side pair unchanged.
   localparam gp_t GP_IDENTITY = '{g: 1'b0, p: 1'b1};

endpackage

// File: rtl/gp_merge.sv
// Kogge-Stone combine cell: merges a high-side G/P pair with the lower
// group it spans over.
module gp_merge
   import adder_pkg::*;
(
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g_out,
   output logic p_out
);

   assign g_out = g_hi | (p_hi & g_lo);
   assign p_out = p_hi & p_lo;

endmodule

// File: rtl/seq_prefix_adder_ctrl.sv
// Sequential Kogge-Stone adder: one prefix level per clock over a registered
// G/P array, with valid/ready handshakes on operand and result sides.
module seq_prefix_adder_ctrl
   import adder_pkg::*;
#(
   parameter  int WIDTH  = 16,
   localparam int LEVELS = $clog2(WIDTH)
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVELS - 1);

   state_e             state_r;
   state_e             state_s;
   logic [LVL_W-1:0]   lvl_r;
   logic [WIDTH-1:0]   g_r;
   logic [WIDTH-1:0]   p_r;
   logic [WIDTH-1:0]   p0_r;
   logic               cin_r;
   logic [WIDTH-1:0]   sum_r;
   logic               cout_r;
   logic               out_valid_r;
   logic               in_ready_r;
   logic               busy_r;

   logic [WIDTH-1:0]   g_next_s;
   logic [WIDTH-1:0]   p_next_s;
   logic [WIDTH-1:0]   p0_in_s;
   logic               accept_s;
   logic               last_s;

   assign p0_in_s  = a ^ b;
   assign accept_s = in_valid & in_ready_r & (state_r == IDLE);
   assign last_s   = (state_r == PREFIX) && (lvl_r == LVL_LAST);

   // Per-bit span select and combine; bits below the span see the identity pair and hold.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gp_t cand_s [LEVELS];
      gp_t lo_s;

      for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
         if (i >= (1 << k)) begin : g_span
            assign cand_s[k] = {g_r[i - (1 << k)], p_r[i - (1 << k)]};
         end else begin : g_edge
            assign cand_s[k] = GP_IDENTITY;
         end
      end

      // Select the lo operand for the level currently being applied.
      always_comb begin
         lo_s = GP_IDENTITY;
         for (int k = 0; k < LEVELS; k++) begin
            if (lvl_r == LVL_W'(k)) begin
               lo_s = cand_s[k];
            end else begin
               lo_s = lo_s;
            end
         end
      end

      gp_merge u_merge (
         .g_hi  (g_r[i]),
         .p_hi  (p_r[i]),
         .g_lo  (lo_s.g),
         .p_lo  (lo_s.p),
         .g_out (g_next_s[i]),
         .p_out (p_next_s[i])
      );
   end

   // Next-state logic for the IDLE -> PREFIX -> DONE -> IDLE sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = PREFIX;
            end else begin
               state_s = IDLE;
            end
         end
         PREFIX: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = PREFIX;
            end
         end
         DONE: begin
            if (out_valid_r & out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, handshake flags, G/P array and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         lvl_r       <= '0;
         g_r         <= '0;
         p_r         <= '0;
         p0_r        <= '0;
         cin_r       <= 1'b0;
         sum_r       <= '0;
         cout_r      <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == IDLE);
         busy_r      <= (state_s != IDLE);
         out_valid_r <= (state_s == DONE);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  // Bit 0 absorbs cin so every later carry is just G of the bit below.
                  p0_r   <= p0_in_s;
                  g_r    <= (a & b) | {{(WIDTH-1){1'b0}}, p0_in_s[0] & cin};
                  p_r    <= {p0_in_s[WIDTH-1:1], 1'b0};
                  cin_r  <= cin;
                  lvl_r  <= '0;
               end
            end
            PREFIX: begin
               g_r <= g_next_s;
               p_r <= p_next_s;
               if (last_s) begin
                  sum_r  <= p0_r ^ {g_next_s[WIDTH-2:0], cin_r};
                  cout_r <= g_next_s[WIDTH-1];
                  lvl_r  <= '0;
               end else begin
                  lvl_r  <= lvl_r + LVL_W'(1);
               end
            end
            DONE: begin
               lvl_r <= '0;
            end
            default: begin
               lvl_r <= '0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign sum       = sum_r;
   assign cout      = cout_r;

endmodule
